// File: rtl/pc_fetch_predictor.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit direction counters.
// Optional BTB_PERF_CNT_EN adds branch/mispredict performance counters.
module pc_fetch_predictor #(
   parameter int          ENTRIES  = 16,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        mispredict_i,
   input  logic [31:0] pc_jump_i,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i,
   output logic [31:0] pc_if_o,
   output logic        pred_taken_o,
   output logic [31:0] pred_target_o
`ifdef BTB_PERF_CNT_EN
   ,
   output logic [31:0] perf_branches_o,
   output logic [31:0] perf_mispred_o
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             valid_q [ENTRIES];
   logic [1:0]       ctr_q   [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [31:0]      tgt_q   [ENTRIES];

   logic [31:0]      pc_if_q;
   logic [31:0]      pc_next;
   logic [IDX_W-1:0] look_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] look_tag;
   logic [TAG_W-1:0] upd_tag;
   logic             look_hit;
   logic             upd_hit;
   logic             unused_upd_lsb;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   assign look_idx = pc_if_q[IDX_W+1:2];
   assign look_tag = pc_if_q[31:IDX_W+2];
   assign upd_idx  = upd_pc_i[IDX_W+1:2];
   assign upd_tag  = upd_pc_i[31:IDX_W+2];
   assign unused_upd_lsb = ^upd_pc_i[1:0];

   assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
   assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   assign pc_if_o       = pc_if_q;
   assign pred_taken_o  = look_hit && ctr_q[look_idx][1];
   assign pred_target_o = look_hit ? tgt_q[look_idx] : 32'h0;

   // Redirect beats stall, stall beats prediction, prediction beats sequential.
   always_comb begin
      pc_next = pc_if_q + 32'd4;
      if (mispredict_i)
         pc_next = pc_jump_i & 32'hFFFF_FFFC;
      else if (stall_i)
         pc_next = pc_if_q;
      else if (pred_taken_o)
         pc_next = pred_target_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         pc_if_q <= RESET_PC;
      else
         pc_if_q <= pc_next;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (upd_valid_i) begin
         if (upd_hit)
            ctr_q[upd_idx] <= upd_taken_i ? ctr_inc(ctr_q[upd_idx]) : ctr_dec(ctr_q[upd_idx]);
         else if (upd_taken_i) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= 2'b10;
         end
      end
   end

   // Tag/target carry no reset; valid gates their use. A taken hit rewrites an identical tag.
   always_ff @(posedge clk_i) begin
      if (upd_valid_i && upd_taken_i) begin
         tag_q[upd_idx] <= upd_tag;
         tgt_q[upd_idx] <= upd_target_i;
      end
   end

`ifdef BTB_PERF_CNT_EN
   logic [31:0] perf_branches_q;
   logic [31:0] perf_mispred_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_branches_q <= 32'h0;
         perf_mispred_q  <= 32'h0;
      end else begin
         if (upd_valid_i)
            perf_branches_q <= perf_branches_q + 32'd1;
         if (mispredict_i)
            perf_mispred_q <= perf_mispred_q + 32'd1;
      end
   end

   assign perf_branches_o = perf_branches_q;
   assign perf_mispred_o  = perf_mispred_q;
`endif

endmodule

// File: tb/tb_pc_fetch_predictor.sv
// Scoreboard bench for pc_fetch_predictor: expected PCs are queued at drive time
// and compared one cycle later; prediction outputs are checked against constants.
module tb_pc_fetch_predictor;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        stall_i;
   logic        mispredict_i;
   logic [31:0] pc_jump_i;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic [31:0] pc_if_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] exp_q[$];

   pc_fetch_predictor #(.ENTRIES(16), .RESET_PC(32'h0)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .stall_i      (stall_i),
      .mispredict_i (mispredict_i),
      .pc_jump_i    (pc_jump_i),
      .upd_valid_i  (upd_valid_i),
      .upd_pc_i     (upd_pc_i),
      .upd_taken_i  (upd_taken_i),
      .upd_target_i (upd_target_i),
      .pc_if_o      (pc_if_o),
      .pred_taken_o (pred_taken_o),
      .pred_target_o(pred_target_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL timeout: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      stall_i = 1'b0; mispredict_i = 1'b0; pc_jump_i = 32'h0;
      upd_valid_i = 1'b0; upd_pc_i = 32'h0; upd_taken_i = 1'b0; upd_target_i = 32'h0;
   endtask

   // Drive one cycle at negedge, queue the expected next PC, compare at the following negedge.
   task automatic step(input string tag, input logic st, input logic mis, input logic [31:0] jmp,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic [31:0] exp_pc);
      stall_i = st; mispredict_i = mis; pc_jump_i = jmp;
      upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utg;
      exp_q.push_back(exp_pc);
      @(posedge clk_i);
      @(negedge clk_i);
      idle_inputs();
      if (exp_q.size() == 0) chk({tag, "_empty"}, 32'h1, 32'h0);
      else chk(tag, pc_if_o, exp_q.pop_front());
   endtask

   task automatic seq(input string tag, input logic [31:0] exp_pc);
      step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, exp_pc);
   endtask

   task automatic redir(input string tag, input logic [31:0] jmp, input logic [31:0] exp_pc);
      step(tag, 1'b0, 1'b1, jmp, 1'b0, 32'h0, 1'b0, 32'h0, exp_pc);
   endtask

   task automatic train(input string tag, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg, input logic [31:0] exp_pc);
      step(tag, 1'b0, 1'b0, 32'h0, 1'b1, upc, ut, utg, exp_pc);
   endtask

   task automatic chk_pred(input string tag, input logic tk, input logic [31:0] tgt);
      chk({tag, "_taken"}, {31'h0, pred_taken_o}, {31'h0, tk});
      chk({tag, "_target"}, pred_target_o, tgt);
   endtask

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rst_pc", pc_if_o, 32'h0);
      chk_pred("rst", 1'b0, 32'h0);
      rst_ni = 1'b1;
      chk("rel_pc", pc_if_o, 32'h0);
      seq("seq1", 32'h4);
      seq("seq2", 32'h8);

      step("stall1", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8);
      step("stall2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8);
      seq("stall_rel", 32'hC);

      step("redir_prio", 1'b1, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);

      train("train_alloc", 32'h20, 1'b1, 32'h80, 32'h104);
      redir("to_20a", 32'h20, 32'h20);
      chk_pred("pred_20a", 1'b1, 32'h80);
      seq("follow_80a", 32'h80);

      train("nt1", 32'h20, 1'b0, 32'h0, 32'h84);
      train("nt2", 32'h20, 1'b0, 32'h0, 32'h88);
      train("nt3", 32'h20, 1'b0, 32'h0, 32'h8C);
      redir("to_20b", 32'h20, 32'h20);
      chk_pred("pred_20b", 1'b0, 32'h80);
      seq("nt_seq", 32'h24);
      train("tk1", 32'h20, 1'b1, 32'h80, 32'h28);
      train("tk2", 32'h20, 1'b1, 32'h80, 32'h2C);
      redir("to_20c", 32'h20, 32'h20);
      chk_pred("pred_20c", 1'b1, 32'h80);
      seq("follow_80c", 32'h80);

      redir("to_60a", 32'h60, 32'h60);
      chk_pred("alias_miss", 1'b0, 32'h0);
      train("bypass_60", 32'h60, 1'b1, 32'h200, 32'h64);
      redir("to_60b", 32'h60, 32'h60);
      chk_pred("pred_60", 1'b1, 32'h200);
      step("stall_hit", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h60);
      seq("follow_200", 32'h200);
      redir("to_20d", 32'h20, 32'h20);
      chk_pred("evicted_20", 1'b0, 32'h0);
      seq("evict_seq", 32'h24);

      train("miss_nt", 32'h40, 1'b0, 32'h300, 32'h28);
      redir("to_40", 32'h40, 32'h40);
      chk_pred("pred_40", 1'b0, 32'h0);

      redir("to_top", 32'hFFFF_FFFF, 32'hFFFF_FFFC);
      seq("wrap", 32'h0);

      redir("to_60c", 32'h60, 32'h60);
      chk_pred("pred_60c", 1'b1, 32'h200);
      rst_ni = 1'b0;
      #1;
      chk("midrst_pc", pc_if_o, 32'h0);
      chk_pred("midrst", 1'b0, 32'h0);
      @(negedge clk_i);
      chk("midrst_hold", pc_if_o, 32'h0);
      rst_ni = 1'b1;
      seq("post_rst1", 32'h4);
      seq("post_rst2", 32'h8);
      redir("to_60d", 32'h60, 32'h60);
      chk_pred("cleared_60", 1'b0, 32'h0);

      if (exp_q.size() != 0) chk("queue_left", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_predictor.md
Name: pc_fetch_predictor

Overview:
- Fetch-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Receives the hazard unit's outputs: stall for PC hold, mispredict for compare-fail, and the corrected target from EX.
- Produces the IF-stage PC and a taken prediction.
- Trains the BTB from the resolved branch/jump in EX, so the IF/ID prediction carried to EX matches resolution more often.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..256.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- stall_i  input  1  hold PC (hazard unit stall_PC).
- mispredict_i  input  1  EX target differs from ID PC; redirect (hazard unit comp_o).
- pc_jump_i  input  32  correct next PC from EX (hazard unit PC_jump_EX).
- upd_valid_i  input  1  EX holds a resolved branch/jump (op_ex[6:4]==3'b110); one cycle per instruction.
- upd_pc_i  input  32  PC of the EX instruction.
- upd_taken_i  input  1  branch resolved taken (PCSel_EX).
- upd_target_i  input  32  resolved target (alu result).
- pc_if_o  output  32  current fetch PC (registered).
- pred_taken_o  output  1  BTB hit with counter[1]==1 for pc_if_o (combinational from pc_if_o).
- pred_target_o  output  32  BTB target for pc_if_o; 0 when no hit.

Behaviour:
- IDX_W = $clog2(ENTRIES).
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2].
- Each entry holds: valid, tag, target[31:0], ctr[1:0].
- Reset (async, rst_ni low):
  - pc_if_o = RESET_PC.
  - All valid = 0, all ctr = 2'b01.
  - Targets and tags need no reset.
  - pred_taken_o = 0, pred_target_o = 0 while reset is held.
- Lookup (combinational on pc_if_o):
  - hit = valid && tag match.
  - pred_taken_o = hit && ctr[1].
  - pred_target_o = hit ? target : 0.
- Next PC priority, per cycle:
  1. mispredict_i: pc_jump_i with bits [1:0] forced to 0. Overrides stall_i.
  2. stall_i: hold pc_if_o.
  3. pred_taken_o: pred_target_o.
  4. Otherwise pc_if_o + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0).
- PC latency: one cycle from input to pc_if_o.
- BTB update on a clock edge when upd_valid_i=1, indexed by upd_pc_i:
  - Hit, taken: ctr saturating +1 (max 3); target = upd_target_i.
  - Hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate and overwrite any aliasing entry. valid=1, tag and target from inputs, ctr=2'b10.
  - Miss, not taken: no change.
- Updates are independent of stall_i and mispredict_i; a mispredicting branch still trains.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents; the write is visible the next cycle.
- upd_valid_i held high for N cycles performs N updates. De-duplication is the caller's responsibility.
- Reset mid-operation clears state immediately regardless of pending updates.

Optional Feature:
- Macro: BTB_PERF_CNT_EN.
- Defined: adds ports perf_branches_o [31:0] and perf_mispred_o [31:0].
  - Registered counters, reset to 0, wrap on overflow.
  - perf_branches_o increments on each upd_valid_i cycle.
  - perf_mispred_o increments on each mispredict_i cycle.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: rst_ni=0 mid-run -> pc_if_o=0x0 immediately and pred_taken_o=0; after release pc_if_o steps 0x0, 0x4, 0x8.
- Stall: stall_i=1 for 2 cycles at pc 0x8 -> pc_if_o holds 0x8 two cycles, then 0xC.
- Redirect priority: mispredict_i=1, stall_i=1, pc_jump_i=0x103 -> next pc_if_o=0x100.
- Train and predict: update upd_pc=0x20, taken, target=0x80 -> ctr=10; when pc_if_o=0x20, pred_taken_o=1, pred_target_o=0x80, next pc 0x80.
- Saturation: on that entry, 3 not-taken updates -> ctr 01, 00, 00; pc 0x20 predicts not taken, next pc 0x24. Then 2 taken -> ctr 10, predicts 0x80 again.
- Alias/bypass (ENTRIES=16): pc_if_o=0x60 with entry from 0x20 -> miss, next pc 0x64. Same-cycle taken update for 0x60 -> old lookup used; the next visit to 0x60 hits.
